// File: rtl/rom_pkg.sv
// Shared definitions for the ROM arbiter slice.
//   ANCHO_DIR_DEF / ANCHO_DATO_DEF : default address and data widths
//   PROF_DEF                       : number of populated ROM words
//   INACTIVO / LEER / ENTREGA      : sequencer state encoding
package rom_pkg;

  localparam int ANCHO_DIR_DEF  = 8;
  localparam int ANCHO_DATO_DEF = 8;
  localparam int PROF_DEF       = 11;

  localparam logic [1:0] INACTIVO = 2'd0;
  localparam logic [1:0] LEER     = 2'd1;
  localparam logic [1:0] ENTREGA  = 2'd2;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin pick, purely combinational.
//   sol_0, sol_1 : pending requests
//   ptr          : priority pointer (0 favours requester 0, 1 favours requester 1)
//   gana_0/1     : one-hot grant; both low when nobody requests
module arbitro_rr2 (
  input  logic sol_0,
  input  logic sol_1,
  input  logic ptr,
  output logic gana_0,
  output logic gana_1
);

  // A lone requester always wins; the pointer only breaks ties.
  assign gana_0 = sol_0 & (~sol_1 | ~ptr);
  assign gana_1 = sol_1 & (~sol_0 |  ptr);

endmodule

// File: rtl/arbitro_rom.sv
// Round-robin sequencer sharing one combinational ROM between two readers.
//   clk, rst_n          : clock, asynchronous active-low reset
//   sol_0/dir_0         : requester 0 request level and address
//   sol_1/dir_1         : requester 1 request level and address
//   direccion           : registered address to the ROM
//   dato_rom            : ROM data, combinational from direccion
//   dato_s              : registered read data shared by both requesters
//   valido_0/valido_1   : one-cycle ownership pulse for dato_s/err_rango
//   err_rango           : address was beyond the populated ROM, dato_s is 0
//   ocupado             : a transaction is in flight
module arbitro_rom
  import rom_pkg::*;
#(
  parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter int ANCHO_DATO = ANCHO_DATO_DEF,
  parameter int PROF       = PROF_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sol_0,
  input  logic [ANCHO_DIR-1:0]  dir_0,
  input  logic                  sol_1,
  input  logic [ANCHO_DIR-1:0]  dir_1,
  output logic [ANCHO_DIR-1:0]  direccion,
  input  logic [ANCHO_DATO-1:0] dato_rom,
  output logic [ANCHO_DATO-1:0] dato_s,
  output logic                  valido_0,
  output logic                  valido_1,
  output logic                  err_rango,
  output logic                  ocupado
);

  // One extra bit so a fully populated ROM (PROF = 2**ANCHO_DIR) still compares.
  localparam logic [ANCHO_DIR:0] LIMITE = PROF[ANCHO_DIR:0];

  logic [1:0]           estado;
  logic                 ptr;
  logic                 dueno;
  logic                 err_pend;
  logic                 gana_0;
  logic                 gana_1;
  logic [ANCHO_DIR-1:0] dir_sel;
  logic                 fuera;

  arbitro_rr2 u_rr (
    .sol_0  (sol_0),
    .sol_1  (sol_1),
    .ptr    (ptr),
    .gana_0 (gana_0),
    .gana_1 (gana_1)
  );

  assign dir_sel = gana_1 ? dir_1 : dir_0;
  assign fuera   = ({1'b0, dir_sel} >= LIMITE);

  // NOTE: every register here, pointer included, is reset so an aborted
  // transaction leaves nothing behind and arbitration restarts at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= INACTIVO;
      ptr       <= 1'b0;
      dueno     <= 1'b0;
      err_pend  <= 1'b0;
      direccion <= '0;
      dato_s    <= '0;
      err_rango <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the pre-edge
      // values of the others, independent of statement order.
      case (estado)
        INACTIVO: begin
          if (gana_0 || gana_1) begin
            direccion <= dir_sel;
            dueno     <= gana_1;
            err_pend  <= fuera;
            estado    <= LEER;
          end
        end
        LEER: begin
          // Out-of-range reads never forward the ROM's undefined output.
          dato_s    <= err_pend ? '0 : dato_rom;
          err_rango <= err_pend;
          estado    <= ENTREGA;
        end
        ENTREGA: begin
          ptr    <= ~dueno;
          estado <= INACTIVO;
        end
        default: estado <= INACTIVO;
      endcase
    end
  end

  // Decoded from registered state only, so the pulses are glitch-free
  // and mutually exclusive by construction.
  assign valido_0 = (estado == ENTREGA) && !dueno;
  assign valido_1 = (estado == ENTREGA) &&  dueno;
  assign ocupado  = (estado != INACTIVO);

endmodule

// File: tb/tb_arbitro_rom.sv
// Self-checking bench for arbitro_rom with a behavioural ROM.
// Expected transactions are queued when stimulus is driven and retired by a
// monitor whenever a valido pulse appears.
module tb_arbitro_rom;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sol_0, sol_1;
  logic [7:0] dir_0, dir_1;
  logic [7:0] direccion;
  logic [7:0] dato_rom;
  logic [7:0] dato_s;
  logic       valido_0, valido_1, err_rango, ocupado;

  int errors = 0;
  int checks = 0;
  int pulsos = 0;

  typedef struct {
    logic       dueno;
    logic [7:0] dato;
    logic       err;
  } exp_t;

  exp_t cola[$];

  logic [7:0] rom_mem [11] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                               8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};

  always #5 clk = ~clk;

  // Behavioural ROM: undefined output beyond the populated words.
  always_comb begin
    dato_rom = 'x;
    if (direccion < 8'd11) dato_rom = rom_mem[direccion[3:0]];
  end

  arbitro_rom dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sol_0     (sol_0),
    .dir_0     (dir_0),
    .sol_1     (sol_1),
    .dir_1     (dir_1),
    .direccion (direccion),
    .dato_rom  (dato_rom),
    .dato_s    (dato_s),
    .valido_0  (valido_0),
    .valido_1  (valido_1),
    .err_rango (err_rango),
    .ocupado   (ocupado)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t esperado(input logic dueno, input logic [7:0] dir);
    exp_t e;
    e.dueno = dueno;
    e.err   = (dir >= 8'd11);
    e.dato  = e.err ? 8'h00 : rom_mem[dir[3:0]];
    return e;
  endfunction

  // Inputs change and checks run just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n = 0;
    while (pulsos < target && n < budget) begin
      step();
      n++;
    end
    check("timeout", (pulsos >= target), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_out", {direccion, dato_s, valido_0, valido_1, err_rango, ocupado}, 0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && (valido_0 || valido_1)) begin
      exp_t e;
      pulsos++;
      check("exclusivo", {31'd0, valido_0 & valido_1}, 0);
      check("pendiente", (cola.size() > 0), 1);
      if (cola.size() > 0) begin
        e = cola.pop_front();
        check("dueno", {31'd0, valido_1}, {31'd0, e.dueno});
        check("dato_s", {24'd0, dato_s}, {24'd0, e.dato});
        check("err_rango", {31'd0, err_rango}, {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [7:0] dirs [4] = '{8'd10, 8'd11, 8'd15, 8'd255};
    int p;

    rst_n = 1'b1;
    sol_0 = 1'b0; sol_1 = 1'b0;
    dir_0 = 8'd0; dir_1 = 8'd0;
    #2;

    // 1: reset values, then idle with no requests.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle", {ocupado, valido_0, valido_1}, 0);
    end
    check("idle_pulsos", pulsos, 0);

    // 2: single read with latency checks.
    sol_0 = 1'b1; dir_0 = 8'd3;
    cola.push_back(esperado(1'b0, 8'd3));
    step();
    check("grant_dir", direccion, 3);
    check("grant_ocupado", ocupado, 1);
    check("grant_no_valido", {valido_0, valido_1}, 0);
    step();
    check("entrega_valido0", {valido_0, valido_1}, 2'b10);
    sol_0 = 1'b0;
    step();
    check("vuelta_inactivo", {ocupado, valido_0, valido_1}, 0);
    check("dato_retenido", dato_s, 8'h44);

    // 3: contention from a fresh pointer, order 0,1,0,1.
    do_reset();
    p = pulsos;
    sol_0 = 1'b1; dir_0 = 8'd5;
    sol_1 = 1'b1; dir_1 = 8'd8;
    for (int i = 0; i < 2; i++) begin
      cola.push_back(esperado(1'b0, 8'd5));
      cola.push_back(esperado(1'b1, 8'd8));
    end
    wait_pulses(p + 4, 40);
    sol_0 = 1'b0; sol_1 = 1'b0;
    step();
    step();
    check("contencion_fin", pulsos, p + 4);

    // 4: range boundary on requester 1, back-to-back.
    sol_1 = 1'b1;
    foreach (dirs[i]) begin
      p = pulsos;
      dir_1 = dirs[i];
      cola.push_back(esperado(1'b1, dirs[i]));
      wait_pulses(p + 1, 10);
    end
    sol_1 = 1'b0;
    step();
    step();

    // 5: withdrawal after grant still completes with the latched address.
    p = pulsos;
    sol_0 = 1'b1; dir_0 = 8'd0;
    cola.push_back(esperado(1'b0, 8'd0));
    step();
    sol_0 = 1'b0; dir_0 = 8'd7;
    check("retiro_dir", direccion, 0);
    wait_pulses(p + 1, 10);
    step();
    step();
    check("retiro_unico", pulsos, p + 1);

    // 6: reset during LEER drops the transaction and rewinds the pointer.
    p = pulsos;
    sol_0 = 1'b1; dir_0 = 8'd3;
    step();
    check("leer_ocupado", ocupado, 1);
    sol_0 = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      check("tras_reset", {ocupado, valido_0, valido_1}, 0);
    end
    check("sin_pulso", pulsos, p);
    sol_0 = 1'b1; dir_0 = 8'd5;
    sol_1 = 1'b1; dir_1 = 8'd8;
    cola.push_back(esperado(1'b0, 8'd5));
    wait_pulses(p + 1, 10);
    sol_0 = 1'b0; sol_1 = 1'b0;
    step();
    step();
    check("ptr_reset_unico", pulsos, p + 1);

    check("cola_final", cola.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
